fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 123 ++++++++++++
 tb/tb_fb_scanout.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: fetches a framebuffer from DDRAM into a word FIFO and scans it out through an 8bpp palette
// clk_sys, reset        : clock and asynchronous active-high reset
// ce_pix, hblank, vblank: video timing; a vblank rising edge starts a new frame
// ch_addr/req/rnw       : DDRAM read request, at most one outstanding
// ch_ready, ch_dout     : DDRAM read data strobe and word
// pal_addr, pal_data    : synchronous palette RAM, one cycle read latency
// rgb, de               : pixel output two cycles after its active-pixel cycle
// underflow             : sticky flag, set when an active pixel finds the FIFO empty
module fb_scanout #(
  parameter logic [28:0] FB_WBASE    = 29'h06000000,
  parameter int          FRAME_WORDS = 43200,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hblank,
  input  logic        vblank,
  output logic [28:0] ch_addr,
  output logic        ch_req,
  output logic        ch_rnw,
  input  logic        ch_ready,
  input  logic [63:0] ch_dout,
  output logic [7:0]  pal_addr,
  input  logic [23:0] pal_data,
  output logic [23:0] rgb,
  output logic        de,
  output logic        underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] FW_C = FRAME_WORDS[CW-1:0];
  typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;
  st_t st_q, st_d;
  logic vb_q, disc_q, disc_d;
  logic [CW-1:0] fet_q, fet_d;
  logic [28:0] addr_q, addr_d;
  logic [AW:0] cnt_q;
  logic [AW-1:0] wp_q, rp_q;
  logic [63:0] mem [FIFO_DEPTH];
  logic [63:0] head;
  logic [2:0] bi_q;
  logic [7:0] pa_q;
  logic [23:0] rgb_q;
  logic act_q, de_q, uf_q;
  logic fs, act, empty, push, pop;
  assign fs = vblank & ~vb_q;
  assign act = ce_pix & ~hblank & ~vblank;
  assign empty = cnt_q == '0;
  assign head = mem[rp_q];
  // a word answering a request from before the frame start is dropped
  assign push = (st_q == WAIT) & ch_ready & ~disc_q & ~fs;
  assign pop = act & ~empty & (bi_q == 3'd7);
  assign ch_req = st_q == REQ;
  assign ch_rnw = 1'b1;
  assign ch_addr = addr_q;
  assign pal_addr = pa_q;
  assign de = de_q;
  assign underflow = uf_q;
  assign rgb = de_q ? pal_data : rgb_q;
  always_comb begin
    st_d = st_q;
    disc_d = disc_q;
    fet_d = push ? fet_q + 1'b1 : fet_q;
    addr_d = addr_q;
    unique case (st_q)
      IDLE: if (!fs && cnt_q < DEPTH_C && fet_q < FW_C) begin
        st_d = REQ;
        addr_d = FB_WBASE + 29'(fet_q);
      end
      REQ: st_d = WAIT;
      WAIT: if (ch_ready) begin
        st_d = IDLE;
        disc_d = 1'b0;
      end
      default: st_d = IDLE;
    endcase
    if (fs) begin
      fet_d = '0;
      if (st_q == REQ || (st_q == WAIT && !ch_ready)) disc_d = 1'b1;
    end
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      vb_q <= 1'b0;
      disc_q <= 1'b0;
      fet_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      st_q <= st_d;
      vb_q <= vblank;
      disc_q <= disc_d;
      fet_q <= fet_d;
      addr_q <= addr_d;
      cnt_q <= fs ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      wp_q <= fs ? '0 : wp_q + AW'(push);
      rp_q <= fs ? '0 : rp_q + AW'(pop);
    end
  always_ff @(posedge clk_sys)
    if (push) mem[wp_q] <= ch_dout;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      bi_q <= '0;
      pa_q <= '0;
      uf_q <= 1'b0;
      act_q <= 1'b0;
      de_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      bi_q <= fs ? 3'd0 : (act && !empty) ? bi_q + 3'd1 : bi_q;
      if (act) pa_q <= empty ? 8'd0 : head[{bi_q, 3'b000} +: 8];
      uf_q <= uf_q | (act & empty);
      act_q <= act;
      de_q <= act_q;
      rgb_q <= rgb;
    end
  assert property (@(posedge clk_sys) disable iff (reset) push |-> cnt_q < DEPTH_C);
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized and directed checks of fb_scanout against a queue-based model
module tb_fb_scanout;
  localparam logic [28:0] BASE = 29'h06000000;
  localparam int FW = 43200;
  logic clk_sys = 0, reset = 1, ce_pix = 0, hblank = 0, vblank = 0, ch_ready = 0, ch_ready2 = 0;
  logic [63:0] ch_dout = 0;
  logic [28:0] ch_addr, ch_addr2;
  logic ch_req, ch_rnw, ch_req2, ch_rnw2, de, de2, underflow, underflow2;
  logic [7:0] pal_addr, pal_addr2;
  logic [23:0] pal_data, pal_data2, rgb, rgb2;
  fb_scanout u_dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .ch_addr(ch_addr), .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_ready(ch_ready), .ch_dout(ch_dout),
    .pal_addr(pal_addr), .pal_data(pal_data), .rgb(rgb), .de(de), .underflow(underflow));
  fb_scanout #(.FRAME_WORDS(4)) u_dut4 (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .ch_addr(ch_addr2), .ch_req(ch_req2), .ch_rnw(ch_rnw2), .ch_ready(ch_ready2), .ch_dout(ch_dout),
    .pal_addr(pal_addr2), .pal_data(pal_data2), .rgb(rgb2), .de(de2), .underflow(underflow2));
  always #5 clk_sys = ~clk_sys;
  function automatic logic [23:0] pal_fn(logic [7:0] a);
    return {a, ~a, a ^ 8'h5a};
  endfunction
  always @(posedge clk_sys) pal_data <= pal_fn(pal_addr);
  always @(posedge clk_sys) pal_data2 <= pal_fn(pal_addr2);
  int total = 0, bad = 0;
  logic [63:0] m_q[$];
  int m_fet, m_bi;
  bit m_out, m_arm, m_disc, m_vbp, m_uf, h1a, h2a;
  logic [7:0] m_pa, h1p, h2p;
  logic [23:0] m_rgb;
  int req_n, req2_n;
  logic [28:0] req_addr[$], req2_addr[$];
  int resp_cnt = 0, dly_lo = 1, dly_hi = 1, dmode = 0;
  bit hold = 0, spur_en = 0, force_spur = 0, r2 = 0;
  bit s_rst, s_act, s_vb, s_rdy;
  logic [63:0] s_dout;
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  function automatic logic [63:0] mk();
    return dmode == 1 ? 64'h0706050403020100 : dmode == 2 ? '1 : {$urandom, $urandom};
  endfunction
  task automatic tick();
    bit fs;
    logic [63:0] w;
    @(posedge clk_sys);
    s_rst = reset; s_act = ce_pix & ~hblank & ~vblank; s_vb = vblank; s_rdy = ch_ready; s_dout = ch_dout;
    #1;
    ch_ready = 0; ch_ready2 = r2; r2 = 0;
    if (reset) begin
      resp_cnt = 0; ch_ready2 = 0;
    end else if (resp_cnt > 0) begin
      if (!hold) begin
        resp_cnt--;
        if (resp_cnt == 0) begin ch_ready = 1; ch_dout = mk(); end
      end
    end else if (force_spur || (spur_en && !m_out && $urandom_range(7) == 0)) begin
      ch_ready = 1; ch_dout = mk(); force_spur = 0;
    end
    @(negedge clk_sys);
    if (s_rst || reset) begin
      m_q.delete(); m_fet = 0; m_bi = 0; m_out = 0; m_arm = 0; m_disc = 0; m_vbp = 0; m_uf = 0;
      m_pa = 0; h1a = 0; h2a = 0; h1p = 0; h2p = 0; m_rgb = 0;
      req_n = 0; req2_n = 0; req_addr.delete(); req2_addr.delete(); r2 = 0;
    end else begin
      if (s_act) begin
        if (m_q.size() == 0) begin m_pa = 0; m_uf = 1; end
        else begin
          w = m_q[0]; m_pa = w[8*m_bi +: 8]; m_bi++;
          if (m_bi == 8) begin m_bi = 0; void'(m_q.pop_front()); end
        end
      end
      fs = s_vb && !m_vbp; m_vbp = s_vb;
      if (s_rdy && m_out) begin
        m_out = 0;
        if (!m_disc && !fs) begin m_q.push_back(s_dout); m_fet++; end
        m_disc = 0;
      end
      if (m_arm) begin m_out = 1; m_arm = 0; end
      if (fs) begin m_q.delete(); m_fet = 0; m_bi = 0; m_disc = m_out; end
      h2a = h1a; h2p = h1p; h1a = s_act; h1p = m_pa;
      if (h2a) m_rgb = pal_fn(h2p);
    end
    if (reset) begin
      chk("rst_req", 64'(ch_req), 0); chk("rst_addr", 64'(ch_addr), 0); chk("rst_pal", 64'(pal_addr), 0);
      chk("rst_rgb", 64'(rgb), 0); chk("rst_de", 64'(de), 0); chk("rst_uf", 64'(underflow), 0);
    end else begin
      chk("rnw", 64'(ch_rnw), 1);
      chk("pal_addr", 64'(pal_addr), 64'(m_pa));
      chk("underflow", 64'(underflow), 64'(m_uf));
      chk("de", 64'(de), 64'(h2a));
      chk("rgb", 64'(rgb), 64'(m_rgb));
      chk("de2", 64'(de2), 64'(h2a));
      if (ch_req) begin
        chk("req_addr", 64'(ch_addr), 64'(BASE) + 64'(m_fet));
        chk("req_legal", 64'({m_out, m_q.size() < 16, m_fet < FW}), 64'(3'b011));
        m_arm = 1; req_n++; req_addr.push_back(ch_addr);
        resp_cnt = $urandom_range(dly_hi, dly_lo);
      end
      if (ch_req2) begin req2_n++; req2_addr.push_back(ch_addr2); r2 = 1; end
    end
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    reset = 1; ce_pix = 0; hblank = 0; vblank = 0; hold = 0; spur_en = 0;
    ticks(2);
    reset = 0;
  endtask
  task automatic wait_req(int n);
    for (int i = 0; i < n && req_n == 0; i++) tick();
    chk("wait_req", 64'(req_n > 0), 1);
  endtask
  initial begin
    // reset state, then prefill with a known word and a fixed 3-cycle answer
    dmode = 1; dly_lo = 3; dly_hi = 3;
    ticks(3);
    reset = 0;
    ticks(150);
    chk("fill_reqs", 64'(req_n), 16);
    chk("fill_model", 64'(m_q.size()), 16);
    chk("fill_first", 64'(req_addr[0]), 64'(BASE));
    chk("fill_last", 64'(req_addr[15]), 64'(BASE + 29'd15));
    // ce_pix during hblank consumes nothing
    ce_pix = 1; hblank = 1;
    ticks(10);
    chk("hb_pal", 64'(pal_addr), 0);
    chk("hb_de", 64'(de), 0);
    chk("hb_reqs", 64'(req_n), 16);
    // eight active pixels walk the head word little-endian and pop it
    hblank = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("seq_pal", 64'(pal_addr), 64'(i));
    end
    ce_pix = 0;
    tick();
    chk("lit_de", 64'(de), 1);
    chk("lit_rgb", 64'(rgb), 64'(24'h07f85d));
    tick();
    chk("lit_de_off", 64'(de), 0);
    chk("lit_rgb_hold", 64'(rgb), 64'(24'h07f85d));
    ticks(10);
    chk("pop_refill", 64'(req_n), 17);
    // no answers at all: underflow sticks across a vblank edge
    do_reset();
    hold = 1;
    ticks(5);
    chk("uf_reqs", 64'(req_n), 1);
    ce_pix = 1;
    ticks(4);
    chk("uf_pal", 64'(pal_addr), 0);
    chk("uf_set", 64'(underflow), 1);
    ce_pix = 0; vblank = 1;
    ticks(3);
    vblank = 0;
    ticks(2);
    chk("uf_sticky", 64'(underflow), 1);
    hold = 0;
    ticks(20);
    // reset in the middle of a wait, then a stray strobe right after release
    do_reset();
    dmode = 0; dly_lo = 8; dly_hi = 8;
    wait_req(20);
    ticks(2);
    reset = 1;
    ticks(2);
    reset = 0; force_spur = 1; dly_lo = 2; dly_hi = 2;
    ticks(30);
    chk("rst_wait_addr", 64'(req_addr[0]), 64'(BASE));
    // frame start while waiting: the late all-ones word is dropped
    do_reset();
    dmode = 2; dly_lo = 6; dly_hi = 6;
    wait_req(20);
    tick();
    vblank = 1;
    ticks(8);
    chk("disc_empty", 64'(m_q.size()), 0);
    chk("disc_restart", 64'(req_addr[1]), 64'(BASE));
    ticks(4);
    vblank = 0;
    ticks(10);
    // randomized frames, lines, delays and stray strobes
    do_reset();
    dmode = 0; dly_lo = 1; spur_en = 1;
    for (int t = 0; t < 4000; t++) begin
      vblank = (t % 1000) >= 900;
      hblank = (t % 100) >= 75;
      ce_pix = 1'($urandom_range(1));
      dly_hi = ((t / 500) % 2) == 1 ? 16 : 4;
      tick();
    end
    chk("rand_reqs", 64'(req_n > 50), 1);
    // four-word frame on the second instance
    do_reset();
    dly_lo = 1; dly_hi = 3; ce_pix = 1;
    ticks(60);
    chk("fw4_reqs", 64'(req2_n), 4);
    chk("fw4_pal", 64'(pal_addr2), 0);
    chk("fw4_rgb", 64'(rgb2), 64'(pal_fn(8'd0)));
    chk("fw4_uf", 64'(underflow2), 1);
    vblank = 1;
    ticks(3);
    vblank = 0;
    ticks(10);
    chk("fw4_resume", 64'(req2_n > 4), 1);
    chk("fw4_addr", 64'(req2_addr[4]), 64'(BASE));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
